wb_arbiter: RTL and testbench

//  Writeback stage directly upstream of the 32-entry register array. Accepts results from the ALU
//  (unbuffered, priority) and the load unit (buffered in a small FIFO). Each cycle it selects at most
//  one result and drives the array's shared data bus G plus a one-hot R_in write-enable, both registered.

---
 rtl/wb_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_wb_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback stage feeding the 32-entry register array.
//
// Merges ALU results (unbuffered, priority) with load results (buffered in a
// small strict-FIFO queue). At most one result per cycle is driven onto the
// shared data bus G together with a one-hot write enable R_in, both
// registered. ld_pending_mask exposes the destinations of buffered loads so
// issue logic can block hazards.
//
// Optional feature macro: WB_STARVE_GUARD_EN
//   defined   : a starvation counter forces a load pop (ALU stalled for one
//               cycle) after STARVE_LIMIT unserved cycles.
//   undefined : ALU always has priority; loads may starve.
//
// Ports:
//   clk, resetn              clock (rising edge), async active-low reset
//   alu_valid/alu_ready      ALU result handshake
//   alu_rd, alu_data         ALU destination index and result (XLEN+1 bits)
//   ld_valid/ld_ready        load result handshake (ld_ready = !queue full)
//   ld_rd, ld_data           load destination index and result (XLEN+1 bits)
//   G                        registered write data to register array
//   R_in                     registered one-hot write enable (bit i -> reg i)
//   wb_valid                 registered, high when R_in carries a write
//   ld_pending_mask          bit i set while a queued load targets reg i
//   lq_count                 load queue occupancy

module wb_arbiter #(
  parameter int XLEN         = 32,
  parameter int LQ_DEPTH     = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        alu_valid,
  output logic                        alu_ready,
  input  logic [4:0]                  alu_rd,
  input  logic [XLEN:0]               alu_data,
  input  logic                        ld_valid,
  output logic                        ld_ready,
  input  logic [4:0]                  ld_rd,
  input  logic [XLEN:0]               ld_data,
  output logic [XLEN:0]               G,
  output logic [XLEN-1:0]             R_in,
  output logic                        wb_valid,
  output logic [31:0]                 ld_pending_mask,
  output logic [$clog2(LQ_DEPTH):0]   lq_count
);

  localparam int AW = $clog2(LQ_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    SEL_IDLE = 2'd0,
    SEL_ALU  = 2'd1,
    SEL_LQ   = 2'd2
  } sel_e;

  // Load queue storage and bookkeeping
  logic [4:0]    lq_rd   [LQ_DEPTH];
  logic [XLEN:0] lq_data [LQ_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          lq_full;
  logic          lq_empty;
  logic          push;
  logic          pop;
  logic          force_pop;

  // Selection results
  sel_e          sel;
  logic [4:0]    win_rd;
  logic [XLEN:0] win_data;
  logic [XLEN-1:0] win_onehot;

  assign lq_full  = (count == CW'(LQ_DEPTH));
  assign lq_empty = (count == '0);
  assign ld_ready = !lq_full;
  assign lq_count = count;

  // Push depends only on registered fullness: a pop in the same cycle does
  // not open a slot for a load presented while full.
  assign push = ld_valid && !lq_full;

`ifdef WB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt;

  assign force_pop = (starve_cnt == SW'(STARVE_LIMIT));

  // The counter never passes STARVE_LIMIT: reaching it forces a pop, which
  // clears it on the following edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt <= '0;
    end else if (pop || lq_empty) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign force_pop = 1'b0;
`endif

  // Arbitration: ALU first unless the starvation guard has tripped.
  always_comb begin
    sel       = SEL_IDLE;
    alu_ready = !force_pop;
    win_rd    = '0;
    win_data  = '0;
    if (alu_valid && !force_pop) begin
      sel      = SEL_ALU;
      win_rd   = alu_rd;
      win_data = alu_data;
    end else if (!lq_empty) begin
      sel      = SEL_LQ;
      win_rd   = lq_rd[rd_ptr];
      win_data = lq_data[rd_ptr];
    end
  end

  assign pop = (sel == SEL_LQ);

  // One-hot decode; register 0 and any bit at or above 32 are never enabled.
  always_comb begin
    win_onehot = '0;
    for (int unsigned i = 1; i < XLEN; i++) begin
      if (i < 32 && win_rd == 5'(i)) begin
        win_onehot[i] = 1'b1;
      end
    end
  end

  // Output register; G holds its last value when idle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      G        <= '0;
      R_in     <= '0;
      wb_valid <= 1'b0;
    end else if (sel == SEL_IDLE) begin
      R_in     <= '0;
      wb_valid <= 1'b0;
    end else begin
      G        <= win_data;
      R_in     <= win_onehot;
      wb_valid <= (win_rd != 5'd0);
    end
  end

  // Queue pointers and occupancy
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Queue payload needs no reset: validity is tracked by count/rd_ptr.
  always_ff @(posedge clk) begin
    if (push) begin
      lq_rd[wr_ptr]   <= ld_rd;
      lq_data[wr_ptr] <= ld_data;
    end
  end

  // Pending mask from the live entries only, so a popped entry drops out on
  // the same edge it leaves the queue.
  always_comb begin
    ld_pending_mask = '0;
    for (int unsigned i = 0; i < LQ_DEPTH; i++) begin
      if (CW'(i) < count) begin
        ld_pending_mask[lq_rd[rd_ptr + AW'(i)]] = 1'b1;
      end
    end
    ld_pending_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

  localparam int XLEN = 32;

  logic          clk;
  logic          resetn;
  logic          alu_valid;
  logic          alu_ready;
  logic [4:0]    alu_rd;
  logic [XLEN:0] alu_data;
  logic          ld_valid;
  logic          ld_ready;
  logic [4:0]    ld_rd;
  logic [XLEN:0] ld_data;
  logic [XLEN:0] G;
  logic [XLEN-1:0] R_in;
  logic          wb_valid;
  logic [31:0]   ld_pending_mask;
  logic [2:0]    lq_count;

  wb_arbiter #(.XLEN(XLEN), .LQ_DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .resetn(resetn),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .G(G), .R_in(R_in), .wb_valid(wb_valid),
    .ld_pending_mask(ld_pending_mask), .lq_count(lq_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]    rd;
    logic [XLEN:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_pass  = 0;
  int  n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] bit_of(input logic [4:0] rd);
    logic [31:0] v;
    v = '0;
    v[rd] = 1'b1;
    return v;
  endfunction

  task automatic expect_wr(input logic [4:0] rd, input logic [XLEN:0] data);
    wr_t w;
    w.rd = rd;
    w.data = data;
    exp_q.push_back(w);
  endtask

  // Monitor: every write presented to the array is popped from the scoreboard.
  always @(negedge clk) begin
    if (resetn && (wb_valid || R_in != '0)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write_R_in", 64'(R_in), 64'd0);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        n_total++;
        if (R_in === bit_of(w.rd) && G === w.data && wb_valid === 1'b1) n_pass++;
        else $display("FAIL write_rd%0d: got R_in=0x%0h G=0x%0h wb_valid=%0b expected R_in=0x%0h G=0x%0h wb_valid=1",
                      w.rd, R_in, G, wb_valid, bit_of(w.rd), w.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alu(input logic v, input logic [4:0] rd, input logic [XLEN:0] d);
    alu_valid = v;
    alu_rd    = rd;
    alu_data  = d;
  endtask

  task automatic drive_ld(input logic v, input logic [4:0] rd, input logic [XLEN:0] d);
    ld_valid = v;
    ld_rd    = rd;
    ld_data  = d;
  endtask

  task automatic drain(input string name);
    for (int t = 0; t < 20 && lq_count != 0; t++) tick();
    chk(name, 64'(lq_count), 64'd0);
    tick();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [XLEN:0] d;
    logic exp_rdy;

    // Reset held with ALU traffic present
    resetn = 1'b0;
    drive_alu(1'b1, 5'd5, 33'h1_DEADBEEF);
    drive_ld(1'b0, 5'd0, '0);
    tick(); tick(); tick();
    chk("rst_G", 64'(G), 64'd0);
    chk("rst_R_in", 64'(R_in), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_ld_ready", 64'(ld_ready), 64'd1);
    chk("rst_lq_count", 64'(lq_count), 64'd0);
    chk("rst_mask", 64'(ld_pending_mask), 64'd0);
    drive_alu(1'b0, 5'd0, '0);
    resetn = 1'b1;
    tick();
    chk("post_rst_alu_ready", 64'(alu_ready), 64'd1);

    // ALU write: one cycle latency, then R_in returns to zero
    expect_wr(5'd5, 33'h1_DEADBEEF);
    drive_alu(1'b1, 5'd5, 33'h1_DEADBEEF);
    tick();
    drive_alu(1'b0, 5'd0, '0);
    chk("alu_R_in", 64'(R_in), 64'h20);
    chk("alu_G", 64'(G), 64'h1_DEADBEEF);
    chk("alu_wb_valid", 64'(wb_valid), 64'd1);
    tick();
    chk("alu_R_in_clear", 64'(R_in), 64'd0);
    chk("alu_G_hold", 64'(G), 64'h1_DEADBEEF);

    // rd 0: handshake completes, no write
    drive_alu(1'b1, 5'd0, 33'h0_000000FF);
    chk("rd0_alu_ready", 64'(alu_ready), 64'd1);
    tick();
    drive_alu(1'b0, 5'd0, '0);
    chk("rd0_R_in", 64'(R_in), 64'd0);
    chk("rd0_wb_valid", 64'(wb_valid), 64'd0);
    tick();

    // Collision: ALU rd 3 written first, load rd 7 next cycle
    expect_wr(5'd3, 33'h0_AAAA0003);
    expect_wr(5'd7, 33'h1_BBBB0007);
    drive_alu(1'b1, 5'd3, 33'h0_AAAA0003);
    drive_ld(1'b1, 5'd7, 33'h1_BBBB0007);
    chk("col_ld_ready", 64'(ld_ready), 64'd1);
    tick();
    drive_alu(1'b0, 5'd0, '0);
    drive_ld(1'b0, 5'd0, '0);
    chk("col_R_in_alu", 64'(R_in), 64'h8);
    chk("col_mask_set", 64'(ld_pending_mask), 64'h80);
    chk("col_count1", 64'(lq_count), 64'd1);
    tick();
    chk("col_R_in_ld", 64'(R_in), 64'h80);
    chk("col_mask_clear", 64'(ld_pending_mask), 64'd0);
    chk("col_count0", 64'(lq_count), 64'd0);
    tick();

    // Full queue under continuous ALU traffic; fifth load stalls
    for (int k = 0; k < 5; k++) expect_wr(5'(10 + k), 33'(32'h0A00 + k));
    for (int k = 0; k < 5; k++) expect_wr(5'(20 + k), 33'(33'h1_0000_0000 + 33'(k)));
    for (int k = 0; k < 4; k++) begin
      drive_alu(1'b1, 5'(10 + k), 33'(32'h0A00 + k));
      drive_ld(1'b1, 5'(20 + k), 33'(33'h1_0000_0000 + 33'(k)));
      tick();
    end
    drive_alu(1'b1, 5'd14, 33'h0_00000A04);
    drive_ld(1'b1, 5'd24, 33'h1_00000004);
    chk("full_count", 64'(lq_count), 64'd4);
    chk("full_ld_ready", 64'(ld_ready), 64'd0);
    chk("full_mask", 64'(ld_pending_mask), 64'h00F0_0000);
    tick();
    drive_alu(1'b0, 5'd0, '0);
    chk("full_ld_ready_stall", 64'(ld_ready), 64'd0);
    tick();
    chk("full_ld_ready_open", 64'(ld_ready), 64'd1);
    chk("full_count3", 64'(lq_count), 64'd3);
    tick();
    drive_ld(1'b0, 5'd0, '0);
    chk("pushpop_count3", 64'(lq_count), 64'd3);
    chk("pushpop_mask", 64'(ld_pending_mask), 64'h01C0_0000);
    drain("full_drain");

    // Starvation: one buffered load under continuous ALU traffic
    d = 33'h100;
    drive_ld(1'b1, 5'd9, 33'h1_0000_0909);
    for (int j = 0; j <= 12; j++) begin
      drive_alu(1'b1, 5'd2, d);
`ifdef WB_STARVE_GUARD_EN
      exp_rdy = (j == 9) ? 1'b0 : 1'b1;
`else
      exp_rdy = 1'b1;
`endif
      chk($sformatf("starve_alu_ready_c%0d", j), 64'(alu_ready), 64'(exp_rdy));
      if (alu_ready) begin
        expect_wr(5'd2, d);
        d = d + 1'b1;
      end else begin
        expect_wr(5'd9, 33'h1_0000_0909);
      end
      tick();
      drive_ld(1'b0, 5'd0, '0);
    end
    drive_alu(1'b0, 5'd0, '0);
`ifdef WB_STARVE_GUARD_EN
    chk("starve_count_guard", 64'(lq_count), 64'd0);
`else
    chk("starve_count_noguard", 64'(lq_count), 64'd1);
    chk("starve_mask_noguard", 64'(ld_pending_mask), 64'h200);
    expect_wr(5'd9, 33'h1_0000_0909);
`endif
    drain("starve_drain");

    // Reset mid-operation discards buffered loads
    drive_alu(1'b1, 5'd0, '0);
    drive_ld(1'b1, 5'd11, 33'h0_11);
    tick();
    drive_ld(1'b1, 5'd12, 33'h0_12);
    tick();
    chk("midrst_count_before", 64'(lq_count), 64'd2);
    chk("midrst_mask_before", 64'(ld_pending_mask), 64'h1800);
    resetn = 1'b0;
    #1;
    chk("midrst_count", 64'(lq_count), 64'd0);
    chk("midrst_mask", 64'(ld_pending_mask), 64'd0);
    chk("midrst_R_in", 64'(R_in), 64'd0);
    drive_alu(1'b0, 5'd0, '0);
    drive_ld(1'b0, 5'd0, '0);
    tick();
    resetn = 1'b1;
    for (int t = 0; t < 5; t++) tick();
    chk("midrst_ld_ready", 64'(ld_ready), 64'd1);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
